// File: rtl/score_display_driver.sv
// -----------------------------------------------------------------------------
// score_display_driver
// Takes the cricket game's score outputs and drives a 4-digit common-anode
// seven-segment display:
//   - digits 3..1 show runs (hundreds/tens/units, with leading-zero blanking)
//   - digit 0 shows wickets, or the winning team once the game is over.
// Runs are converted to BCD by a sequential double-dabble FSM. The FSM only
// publishes a fully converted result, so the display never shows a partial
// value.
//
// Ports
//   clk_fpga      in   system clock; all state changes on its rising edge
//   reset         in   asynchronous active-low reset
//   binaryRuns    in   [7:0] runs, 0..255
//   binaryWickets in   [3:0] wickets, 0..15 (10..15 shown as 'A')
//   inningOver    in   innings complete; lights digit 0 dp
//   gameOver      in   match complete; digit 0 shows winner, dp blinks
//   winner        in   0 = team 1, 1 = team 2
//   an            out  [3:0] digit enables, active-low, an[3] leftmost
//   seg           out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp            out  decimal point, active-low
//   conv_busy     out  high while a BCD conversion is running
// -----------------------------------------------------------------------------
module score_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic [7:0] binaryRuns,
  input  logic [3:0] binaryWickets,
  input  logic       inningOver,
  input  logic       gameOver,
  input  logic       winner,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       conv_busy
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // ---------------------------------------------------------------------------
  // BCD conversion
  // ---------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [19:0] r_shreg;     // {hundreds, tens, units, binary}
  logic [2:0]  r_iter;
  logic [7:0]  r_last_runs;
  logic [3:0]  r_bcd_h;
  logic [3:0]  r_bcd_t;
  logic [3:0]  r_bcd_u;
  logic        r_conv_busy;
  logic [19:0] w_adj;

  // Add-3 correction on each BCD nibble before the shift.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
    assign w_adj[8+4*gi +: 4] = (r_shreg[8+4*gi +: 4] >= 4'd5)
                              ? r_shreg[8+4*gi +: 4] + 4'd3
                              : r_shreg[8+4*gi +: 4];
  end
  assign w_adj[7:0] = r_shreg[7:0];

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_iter      <= '0;
      r_last_runs <= '0;
      r_bcd_h     <= '0;
      r_bcd_t     <= '0;
      r_bcd_u     <= '0;
      r_conv_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Busy rises on the way into LOAD so it covers LOAD..COMMIT.
          if (binaryRuns != r_last_runs) begin
            r_state     <= ST_LOAD;
            r_conv_busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_shreg     <= {12'd0, binaryRuns};
          r_last_runs <= binaryRuns;
          r_iter      <= '0;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_shreg <= {w_adj[18:0], 1'b0};
          r_iter  <= r_iter + 3'd1;
          if (r_iter == 3'd7) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_bcd_h     <= r_shreg[19:16];
          r_bcd_t     <= r_shreg[15:12];
          r_bcd_u     <= r_shreg[11:8];
          r_conv_busy <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh timing and blink
  // ---------------------------------------------------------------------------
  logic [RW-1:0] r_refresh_cnt;
  logic [1:0]    r_digit_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;
  logic          r_tick_d;   // digit_idx changed last cycle: latch new content
  logic          w_tick;

  assign w_tick = (r_refresh_cnt == REFRESH_LAST);

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
      r_blink_cnt   <= '0;
      r_blink       <= 1'b0;
      r_tick_d      <= 1'b0;
    end else begin
      r_tick_d      <= w_tick;
      r_refresh_cnt <= w_tick ? '0 : r_refresh_cnt + RW'(1);
      if (w_tick) begin
        r_digit_idx <= r_digit_idx + 2'd1;
        if (r_digit_idx == 2'd3) begin
          if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
          end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit content
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      4'hA:    seg_code = 7'b0001000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  logic [3:0] w_digit;
  logic       w_blank;
  logic       w_dp;
  logic [6:0] w_seg;
  logic [3:0] w_an;

  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    w_dp    = 1'b1;
    case (r_digit_idx)
      2'd3: begin
        w_digit = r_bcd_h;
        w_blank = (r_bcd_h == 4'd0);
      end
      2'd2: begin
        w_digit = r_bcd_t;
        w_blank = (r_bcd_h == 4'd0) && (r_bcd_t == 4'd0);
      end
      2'd1: begin
        w_digit = r_bcd_u;
        w_dp    = 1'b0;
      end
      default: begin
        if (gameOver) begin
          w_digit = winner ? 4'd2 : 4'd1;
          w_dp    = r_blink;
        end else begin
          // 10 or more wickets reads as 'A' (all out).
          w_digit = (binaryWickets > 4'd9) ? 4'hA : binaryWickets;
          w_dp    = ~inningOver;
        end
      end
    endcase
  end

  assign w_seg = w_blank ? 7'b1111111 : seg_code(w_digit);
  assign w_an  = ~(4'b0001 << r_digit_idx);

  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;

  // Outputs stay dark until the first digit switch after reset.
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (r_tick_d) begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign conv_busy = r_conv_busy;

endmodule

// File: tb/tb_score_display_driver.sv
module tb_score_display_driver;

  logic       clk_fpga;
  logic       reset;
  logic [7:0] binaryRuns;
  logic [3:0] binaryWickets;
  logic       inningOver;
  logic       gameOver;
  logic       winner;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       conv_busy;

  score_display_driver #(
    .REFRESH_DIV(4),
    .BLINK_DIV  (2)
  ) dut (
    .clk_fpga     (clk_fpga),
    .reset        (reset),
    .binaryRuns   (binaryRuns),
    .binaryWickets(binaryWickets),
    .inningOver   (inningOver),
    .gameOver     (gameOver),
    .winner       (winner),
    .an           (an),
    .seg          (seg),
    .dp           (dp),
    .conv_busy    (conv_busy)
  );

  initial clk_fpga = 1'b0;
  always #5 clk_fpga = ~clk_fpga;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: what the display should be showing.
  int m_runs;
  int m_wk;
  bit m_io;
  bit m_go;
  bit m_win;

  logic [6:0] seg_tab [0:10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int idx, output logic [6:0] es, output logic ed, output bit dp_known);
    int h, t, u;
    h = m_runs / 100;
    t = (m_runs / 10) % 10;
    u = m_runs % 10;
    es = 7'h7F;
    ed = 1'b1;
    dp_known = 1'b1;
    case (idx)
      3: es = (h == 0) ? 7'h7F : seg_tab[h];
      2: es = (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
      1: begin es = seg_tab[u]; ed = 1'b0; end
      0: begin
        if (m_go) begin
          es = seg_tab[m_win ? 2 : 1];
          dp_known = 1'b0;
        end else begin
          es = seg_tab[(m_wk > 9) ? 10 : m_wk];
          ed = !m_io;
        end
      end
      default: ;
    endcase
  endtask

  task automatic apply(input int runs, input int wk, input bit io, input bit go, input bit win);
    binaryRuns    = 8'(runs);
    binaryWickets = 4'(wk);
    inningOver    = io;
    gameOver      = go;
    winner        = win;
    m_runs = runs; m_wk = wk; m_io = io; m_go = go; m_win = win;
    $display("apply runs=%0d wkts=%0d inningOver=%0d gameOver=%0d winner=%0d", runs, wk, io, go, win);
  endtask

  task automatic wait_an_change(output bit ok, output int cycles);
    logic [3:0] prev;
    prev = an;
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_fpga);
      cycles++;
      if (an !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Wait for any pending conversion to finish (bounded).
  task automatic settle(input string tag);
    int n;
    n = 0;
    @(negedge clk_fpga);
    while (conv_busy === 1'b1 && n < 40) begin
      @(negedge clk_fpga);
      n++;
    end
    chk({tag, "_conv_done"}, 32'(conv_busy), 0);
  endtask

  // Watch four consecutive digit switches and check each against the model.
  task automatic check_display(input string tag);
    bit ok;
    int cyc;
    int idx;
    logic [6:0] es;
    logic ed;
    bit dk;
    for (int k = 0; k < 4; k++) begin
      wait_an_change(ok, cyc);
      chk({tag, "_switch"}, 32'(ok), 1);
      if (!ok) return;
      if (k > 0) chk({tag, "_period"}, cyc, 4);
      chk({tag, "_onehot"}, $countones(~an), 1);
      idx = -1;
      for (int b = 0; b < 4; b++) if (an[b] == 1'b0) idx = b;
      model(idx, es, ed, dk);
      chk($sformatf("%s_seg%0d", tag, idx), 32'(seg), 32'(es));
      if (dk) chk($sformatf("%s_dp%0d", tag, idx), 32'(dp), 32'(ed));
    end
  endtask

  int busy_cnt;
  int rise_cnt;
  logic prev_busy;
  logic [3:0] prev_an;
  int cyc;
  int nchg;
  int last_chg;
  bit have_base;
  logic base_dp;
  int nr;

  initial begin
    // 1: reset with everything at zero
    reset = 1'b0;
    apply(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_fpga);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 1);
    chk("rst_busy", 32'(conv_busy), 0);
    reset = 1'b1;
    @(negedge clk_fpga);
    chk("pre_tick_an", 32'(an), 32'hF);
    chk("zero_no_conv", 32'(conv_busy), 0);
    check_display("t1_zero");

    // 2: 0 -> 255, busy must last exactly 10 cycles
    apply(255, 0, 0, 0, 0);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_fpga);
      if (conv_busy === 1'b1) busy_cnt++;
    end
    chk("t2_busy_len", busy_cnt, 10);
    check_display("t2_255");

    // 3: 107, then 42 three shifts into the conversion
    apply(107, 0, 0, 0, 0);
    busy_cnt = 0;
    rise_cnt = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_fpga);
      if (conv_busy === 1'b1) busy_cnt++;
      if (conv_busy === 1'b1 && prev_busy === 1'b0) rise_cnt++;
      prev_busy = conv_busy;
      if (i == 4) apply(42, 0, 0, 0, 0);
    end
    chk("t3_busy_total", busy_cnt, 20);
    chk("t3_conversions", rise_cnt, 2);
    check_display("t3_42");

    // 4: wickets and inning flag
    apply(42, 10, 1, 0, 0); settle("t4a"); check_display("t4_all_out");
    apply(42, 7, 0, 0, 0);  settle("t4b"); check_display("t4_wk7");
    apply(42, 9, 1, 0, 0);  settle("t4c"); check_display("t4_wk9");
    apply(42, 15, 0, 0, 0); settle("t4d"); check_display("t4_wk15");

    // Leading-zero blanking boundaries
    apply(100, 1, 0, 0, 0); settle("b100"); check_display("b_100");
    apply(9, 2, 0, 0, 0);   settle("b9");   check_display("b_9");
    apply(10, 3, 0, 0, 0);  settle("b10");  check_display("b_10");
    apply(99, 4, 0, 0, 0);  settle("b99");  check_display("b_99");

    // 5: game over, winner team 2, dp blink period
    apply(99, 4, 1, 1, 1); settle("t5"); check_display("t5_win2");
    prev_an = an;
    cyc = 0; nchg = 0; last_chg = 0; have_base = 1'b0; base_dp = 1'b1;
    for (int i = 0; i < 300 && nchg < 3; i++) begin
      @(negedge clk_fpga);
      cyc++;
      if (an !== prev_an && an === 4'b1110) begin
        if (!have_base) begin
          have_base = 1'b1;
          base_dp = dp;
        end else if (dp !== base_dp) begin
          if (nchg > 0) chk("t5_blink_period", cyc - last_chg, 32);
          nchg++;
          last_chg = cyc;
          base_dp = dp;
        end
      end
      prev_an = an;
    end
    chk("t5_blink_toggles", nchg, 3);
    apply(99, 4, 1, 1, 0); settle("t5b"); check_display("t5_win1");

    // Randomized vectors against the model
    for (int r = 0; r < 10; r++) begin
      apply(int'($urandom_range(255)), int'($urandom_range(15)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      settle("rnd");
      check_display($sformatf("rnd%0d", r));
    end

    // 6: reset in the middle of a conversion
    nr = (m_runs == 173) ? 174 : 173;
    apply(nr, 5, 0, 0, 0);
    repeat (4) @(negedge clk_fpga);
    chk("t6_busy_before", 32'(conv_busy), 1);
    reset = 1'b0;
    #1;
    chk("t6_async_an", 32'(an), 32'hF);
    chk("t6_async_seg", 32'(seg), 32'h7F);
    chk("t6_async_dp", 32'(dp), 1);
    chk("t6_async_busy", 32'(conv_busy), 0);
    repeat (2) @(negedge clk_fpga);
    reset = 1'b1;
    @(negedge clk_fpga);
    chk("t6_pre_tick_an", 32'(an), 32'hF);
    chk("t6_reconvert", 32'(conv_busy), 1);
    settle("t6");
    check_display("t6_recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
